// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer: md_op codes, FSM states
// and the width of the Busy cycle counter.
package md_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NONE  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Codes 0-3 are the only ones that launch a multi-cycle operation.
  function automatic logic is_run_op(logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational mult/multu/div/divu datapath producing the 64-bit {hi,lo} result.
// Divide by zero returns the current HI/LO so the commit leaves them untouched.
module md_arith
  import md_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  md_op_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] result_o
);

  logic signed [63:0] s_prod;
  logic        [63:0] u_prod;
  logic               b_zero;
  logic               div_ovf;
  logic        [31:0] s_div_b;
  logic        [31:0] u_div_b;
  logic signed [31:0] s_quo;
  logic signed [31:0] s_rem;
  logic        [31:0] u_quo;
  logic        [31:0] u_rem;

  assign s_prod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign u_prod = {32'd0, a_i} * {32'd0, b_i};

  assign b_zero  = (b_i == 32'd0);
  assign div_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  // Substitute a harmless divisor for the cases whose result is overridden below.
  assign s_div_b = (b_zero || div_ovf) ? 32'd1 : b_i;
  assign u_div_b = b_zero ? 32'd1 : b_i;

  assign s_quo = $signed(a_i) / $signed(s_div_b);
  assign s_rem = $signed(a_i) % $signed(s_div_b);
  assign u_quo = a_i / u_div_b;
  assign u_rem = a_i % u_div_b;

  always_comb begin
    result_o = {hi_i, lo_i};
    case (md_op_i)
      MD_MULT:  result_o = s_prod;
      MD_MULTU: result_o = u_prod;
      MD_DIV: begin
        if (div_ovf) begin
          result_o = {32'd0, 32'h8000_0000};
        end else if (!b_zero) begin
          result_o = {s_rem, s_quo};
        end
      end
      MD_DIVU: begin
        if (!b_zero) begin
          result_o = {u_rem, u_quo};
        end
      end
      default: result_o = {hi_i, lo_i};
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO owner for the P6 pipeline: launches mult/div ops, holds Busy for a fixed
// cycle count, then commits the shadowed result into HI/LO.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [CNT_W-1:0] MultCnt = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DivCnt  = CNT_W'(DIV_CYCLES);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      shadow_q, shadow_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      arith_result;

  md_arith u_arith (
    .a_i      (A),
    .b_i      (B),
    .md_op_i  (md_op),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .result_o (arith_result)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Start && is_run_op(md_op)) begin
          shadow_d = arith_result;
          cnt_d    = md_op[1] ? DivCnt : MultCnt;
          state_d  = ST_RUN;
        end else if (md_op == MD_MTHI) begin
          hi_d = A;
        end else if (md_op == MD_MTLO) begin
          lo_d = A;
        end
      end
      ST_RUN: begin
        // Start/mthi/mtlo are deliberately ignored here, including on the final edge.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = shadow_q[63:32];
          lo_d    = shadow_q[31:0];
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign Busy = (state_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed scenarios plus randomized ops
// checked against a longint arithmetic reference model.
module tb_md_sequencer;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_tests = 0;
  int n_fail  = 0;

  md_sequencer #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  // Reference: ISA-level semantics on 64-bit integers.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {hi, lo};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      3'd4: return {a, lo};
      3'd5: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present an op for exactly one rising edge, then return to md_op=none.
  task automatic pulse_op(input logic st, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk);
    Start = st;
    md_op = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    md_op = MD_NONE;
  endtask

  // Counts Busy cycles (sampled at negedge) and notes whether HI/LO moved meanwhile.
  task automatic count_busy(output int n, output logic held, input logic [31:0] old_hi,
                            input logic [31:0] old_lo);
    n    = 0;
    held = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!Busy) break;
      n++;
      if (HI !== old_hi || LO !== old_lo) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Start = 1'b0;
    md_op = MD_NONE;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_tests++; if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", HI); end
    n_tests++; if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", LO); end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int n; logic held;
    pulse_op(1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3);
    count_busy(n, held, 32'd0, 32'd0);
    n_tests++; if (n !== 5) begin n_fail++; $display("FAIL mult_busy_len: got %0d want 5", n); end
    n_tests++; if (held !== 1'b1) begin n_fail++; $display("FAIL mult_hold: HI/LO changed during Busy, want held"); end
    n_tests++; if (HI !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
    n_tests++; if (LO !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
  endtask

  task automatic test_multu();
    int n; logic held;
    pulse_op(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    count_busy(n, held, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    n_tests++; if (n !== 5) begin n_fail++; $display("FAIL multu_busy_len: got %0d want 5", n); end
    n_tests++; if (HI !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", HI); end
    n_tests++; if (LO !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", LO); end
  endtask

  task automatic test_div();
    int n; logic held;
    pulse_op(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2);
    count_busy(n, held, 32'hFFFF_FFFE, 32'h0000_0001);
    n_tests++; if (n !== 10) begin n_fail++; $display("FAIL div_busy_len: got %0d want 10", n); end
    n_tests++; if (held !== 1'b1) begin n_fail++; $display("FAIL div_hold: HI/LO changed during Busy, want held"); end
    n_tests++; if (LO !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", LO); end
    n_tests++; if (HI !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", HI); end
  endtask

  task automatic test_div_corner();
    int n; logic held;
    pulse_op(1'b0, MD_MTHI, 32'h11, 32'd0);
    pulse_op(1'b0, MD_MTLO, 32'h22, 32'd0);
    @(negedge clk);
    n_tests++; if (HI !== 32'h11) begin n_fail++; $display("FAIL mthi_nostart: got %h want 11", HI); end
    n_tests++; if (LO !== 32'h22) begin n_fail++; $display("FAIL mtlo_nostart: got %h want 22", LO); end
    pulse_op(1'b1, MD_DIVU, 32'd7, 32'd0);
    count_busy(n, held, 32'h11, 32'h22);
    n_tests++; if (n !== 10) begin n_fail++; $display("FAIL divz_busy_len: got %0d want 10", n); end
    n_tests++; if (HI !== 32'h11) begin n_fail++; $display("FAIL divz_hi: got %h want 11", HI); end
    n_tests++; if (LO !== 32'h22) begin n_fail++; $display("FAIL divz_lo: got %h want 22", LO); end
    pulse_op(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n, held, 32'h11, 32'h22);
    n_tests++; if (n !== 10) begin n_fail++; $display("FAIL divovf_busy_len: got %0d want 10", n); end
    n_tests++; if (LO !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo: got %h want 80000000", LO); end
    n_tests++; if (HI !== 32'd0) begin n_fail++; $display("FAIL divovf_hi: got %h want 0", HI); end
  endtask

  task automatic test_mtlo_idle();
    pulse_op(1'b1, MD_MTLO, 32'h55, 32'd9);
    @(negedge clk);
    n_tests++; if (LO !== 32'h55) begin n_fail++; $display("FAIL mtlo_idle_lo: got %h want 55", LO); end
    n_tests++; if (HI !== 32'd0) begin n_fail++; $display("FAIL mtlo_idle_hi: got %h want 0", HI); end
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_idle_busy: got %b want 0", Busy); end
    pulse_op(1'b1, MD_NONE, 32'h99, 32'h3);
    @(negedge clk);
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL none_busy: got %b want 0", Busy); end
    n_tests++; if (LO !== 32'h55 || HI !== 32'd0) begin
      n_fail++; $display("FAIL none_hilo: got %h/%h want 0/55", HI, LO);
    end
  endtask

  task automatic test_ignored_busy();
    int n; logic held;
    do_reset();
    pulse_op(1'b1, MD_MULT, 32'd3, 32'd4);
    pulse_op(1'b0, MD_MTHI, 32'hAAAA, 32'd0);
    pulse_op(1'b1, MD_DIV, 32'd100, 32'd7);
    count_busy(n, held, 32'd0, 32'd0);
    n_tests++; if (n !== 3) begin n_fail++; $display("FAIL ign_busy_len: got %0d want 3 remaining", n); end
    n_tests++; if (held !== 1'b1) begin n_fail++; $display("FAIL ign_hold: HI/LO changed during Busy, want held"); end
    n_tests++; if (HI !== 32'd0) begin n_fail++; $display("FAIL ign_hi: got %h want 0", HI); end
    n_tests++; if (LO !== 32'd12) begin n_fail++; $display("FAIL ign_lo: got %h want c", LO); end
  endtask

  task automatic test_back_to_back();
    int n; logic held;
    @(negedge clk);
    Start = 1'b1;
    md_op = MD_MULT;
    A     = 32'd2;
    B     = 32'd3;
    @(posedge clk);
    #1;
    count_busy(n, held, 32'd0, 32'd12);
    n_tests++; if (n !== 5) begin n_fail++; $display("FAIL b2b_first_len: got %0d want 5", n); end
    n_tests++; if (LO !== 32'd6) begin n_fail++; $display("FAIL b2b_first_lo: got %h want 6", LO); end
    @(negedge clk);
    n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got %b want 1", Busy); end
    Start = 1'b0;
    md_op = MD_NONE;
    count_busy(n, held, 32'd0, 32'd6);
    n_tests++; if (n !== 4) begin n_fail++; $display("FAIL b2b_second_len: got %0d want 4 remaining", n); end
    n_tests++; if (HI !== 32'd0 || LO !== 32'd6) begin
      n_fail++; $display("FAIL b2b_result: got %h/%h want 0/6", HI, LO);
    end
  endtask

  task automatic test_reset_abort();
    pulse_op(1'b0, MD_MTHI, 32'h1234, 32'd0);
    pulse_op(1'b1, MD_MULT, 32'd5, 32'd6);
    @(posedge clk);
    @(posedge clk);
    #1;
    n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", Busy); end
    #1;
    reset = 1'b1;
    #1;
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", Busy); end
    n_tests++; if (HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++; $display("FAIL abort_hilo: got %h/%h want 0/0", HI, LO);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++; $display("FAIL abort_after: got busy=%b %h/%h want 0 0/0", Busy, HI, LO);
    end
  endtask

  task automatic test_random();
    int n; logic held;
    logic [2:0]  op;
    logic [31:0] a, b, m_hi, m_lo;
    logic [63:0] exp;
    do_reset();
    m_hi = '0;
    m_lo = '0;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 100));
      exp = ref_md(op, a, b, m_hi, m_lo);
      pulse_op(op[2] ? 1'($urandom_range(0, 1)) : 1'b1, op, a, b);
      if (op[2] == 1'b0) begin
        count_busy(n, held, m_hi, m_lo);
        n_tests++; if (n !== (op[1] ? 10 : 5)) begin
          n_fail++; $display("FAIL rnd_busy_len[%0d] op=%0d: got %0d want %0d", i, op, n, op[1] ? 10 : 5);
        end
      end else begin
        @(negedge clk);
        n_tests++; if (Busy !== 1'b0) begin
          n_fail++; $display("FAIL rnd_mv_busy[%0d]: got %b want 0", i, Busy);
        end
      end
      n_tests++; if (HI !== exp[63:32] || LO !== exp[31:0]) begin
        n_fail++;
        $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h: got %h/%h want %h/%h",
                 i, op, a, b, HI, LO, exp[63:32], exp[31:0]);
      end
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_corner();
    test_mtlo_idle();
    test_ignored_busy();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multiply/divide sequencer for the P6 pipeline. Owns the HI/LO registers and runs mult/multu/div/divu as multi-cycle operations.
- Driven from the E stage by the decoder's Start and md_op fields, with operands taken from the forwarded rs/rt values.
- Drives Busy to the hazard unit so that later md instructions and mfhi/mflo stall in D while an operation is in flight.
- HI/LO feed the E-stage result mux, selected by ALUOut_sel.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for mult/multu (legal range 1-15).
- DIV_CYCLES, 10, number of Busy cycles for div/divu (legal range 1-15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  launch a mult/multu/div/divu; valid only when md_op is 0-3.
- md_op  input  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 none.
- A  input  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- B  input  32  rt operand (divisor / multiplier).
- Busy  output  1  operation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (asynchronous, any time): HI=0, LO=0, Busy=0, state=IDLE, cycle counter=0, shadow result discarded. Reset in RUN aborts the operation; HI/LO stay 0.
- State machine: two states, IDLE and RUN.
- IDLE, rising edge with Start=1 and md_op in 0-3:
  - compute the 64-bit result from A/B and latch it into the shadow registers;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- RUN:
  - Busy=1; the counter decrements on each edge.
  - On the edge where the counter goes 1->0: HI/LO take the shadow value, Busy falls, state returns to IDLE.
- Timing: Start sampled at edge t0. Busy is high for exactly N cycles following t0. New HI/LO are visible in the first cycle after Busy falls. Total latency from Start to readable HI/LO is N+1 cycles.
- Busy is registered (a pure state decode); it is not combinational on Start. The hazard unit handles the Start-cycle stall itself.
- mult: {HI,LO} = signed(A) * signed(B).
- multu: {HI,LO} = unsigned(A) * unsigned(B).
- div: LO = signed quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: LO = unsigned quotient, HI = unsigned remainder.
- Divide by zero (B=0, div or divu):
  - Busy still runs for DIV_CYCLES;
  - HI/LO keep their pre-Start values (the shadow is loaded with the old HI/LO).
- mthi (md_op=4) in IDLE: HI<=A at the edge; LO and Busy unchanged; no RUN.
- mtlo (md_op=5) in IDLE: LO<=A at the edge; HI and Busy unchanged; no RUN.
- Any Start, mthi or mtlo while in RUN is ignored. The hazard unit guarantees these do not occur; the bench checks that they have no effect.
- Start=1 with md_op 4-6 starts no operation: 4/5 still act as mthi/mtlo, 6 does nothing.
- md_op=4/5 with Start=0 behaves as mthi/mtlo, matching the decoder's encoding.
- Back-to-back operation: Start can be accepted on the same edge that RUN finishes? No. The state at that edge is RUN, so Start is ignored; the next Start is accepted one cycle later. The hazard unit stalls while Busy is high, so this does not occur in normal operation.

Decomposition:
- Shared package md_pkg holds:
  - md_op encodings MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5, MD_NONE=6;
  - state encodings ST_IDLE, ST_RUN;
  - the counter width constant (4).
- One natural sub-module, md_arith: purely combinational. Inputs A, B, md_op and the current HI/LO; output is the 64-bit {hi,lo} result, including the divide-by-zero hold and INT_MIN/-1 cases.
- md_sequencer keeps the FSM, counter, shadow registers and HI/LO.

Test Plan:
- Reset, then mult A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO are 0 throughout Busy.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 Busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=0xFFFFFFF9 (-7), B=2 -> 10 Busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide corner cases:
  - divu A=7, B=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo -> 10 Busy cycles, HI=0x11, LO=0x22.
  - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Ops ignored while busy: mthi A=0xAAAA during RUN of a mult 3*4 -> ignored; final HI=0, LO=12.
- Ops in IDLE and reset abort:
  - mtlo A=0x55 in IDLE -> LO=0x55 the next cycle, Busy stays 0.
  - reset asserted in the 3rd Busy cycle of a mult -> Busy=0, HI=LO=0 immediately, asynchronously, before the next edge.
